// File: rtl/mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_fill_arbiter
// Description : Shares one pipelined main memory between I-cache block fills,
//               D-cache block fills and D-side write-through stores.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fill_arbiter #(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_miss_req,
    input  logic [15:0] i_miss_addr,
    input  logic        d_miss_req,
    input  logic [15:0] d_miss_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data_out,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        i_fill_valid,
    output logic        d_fill_valid,
    output logic        i_fill_done,
    output logic        d_fill_done,
    output logic        d_wr_ack,
    output logic        busy
);

    localparam logic [15:0] c_BLOCK_MASK = 16'hFFF0;
    localparam logic [3:0]  c_WORDS      = 4'(WORDS_PER_BLOCK);
    localparam logic [2:0]  c_RET_LAST   = 3'(WORDS_PER_BLOCK - 1);

    // The 3-bit word index and 16-byte block mask only support 8-word blocks.
    if (MEM_LATENCY < 1 || WORDS_PER_BLOCK != 8) begin : g_param_check
        $error("mem_fill_arbiter: unsupported MEM_LATENCY/WORDS_PER_BLOCK");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FILL_I = 2'd2,
        ST_FILL_D = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_base;
    logic [3:0]  r_issue_cnt;
    logic [2:0]  r_ret_cnt;
    logic        w_fill;
    logic        w_issue;
    logic        w_ret;

    assign w_fill  = (r_state == ST_FILL_I) || (r_state == ST_FILL_D);
    assign w_issue = w_fill && (r_issue_cnt < c_WORDS);
    assign w_ret   = w_fill && mem_data_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE) begin
                r_issue_cnt <= '0;
                r_ret_cnt   <= '0;
                if (w_state_nxt == ST_FILL_D) begin
                    r_base <= d_miss_addr & c_BLOCK_MASK;
                end else if (w_state_nxt == ST_FILL_I) begin
                    r_base <= i_miss_addr & c_BLOCK_MASK;
                end
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + 4'd1;
                end
                if (w_ret) begin
                    r_ret_cnt <= r_ret_cnt + 3'd1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        fill_data    = '0;
        fill_word    = '0;
        i_fill_valid = 1'b0;
        d_fill_valid = 1'b0;
        i_fill_done  = 1'b0;
        d_fill_done  = 1'b0;
        d_wr_ack     = 1'b0;
        busy         = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                // Fixed priority: stores, then D misses, then I misses.
                if (d_wr_req) begin
                    w_state_nxt = ST_WRITE;
                end else if (d_miss_req) begin
                    w_state_nxt = ST_FILL_D;
                end else if (i_miss_req) begin
                    w_state_nxt = ST_FILL_I;
                end
            end
            ST_WRITE: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_wr_addr;
                mem_data_in = d_wr_data;
                d_wr_ack    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_FILL_I, ST_FILL_D: begin
                // Issues and returns overlap once the memory pipeline fills.
                if (w_issue) begin
                    mem_en   = 1'b1;
                    mem_addr = r_base + {12'd0, r_issue_cnt[2:0], 1'b0};
                end
                if (w_ret) begin
                    fill_data    = mem_data_out;
                    fill_word    = r_ret_cnt;
                    i_fill_valid = (r_state == ST_FILL_I);
                    d_fill_valid = (r_state == ST_FILL_D);
                    if (r_ret_cnt == c_RET_LAST) begin
                        i_fill_done = (r_state == ST_FILL_I);
                        d_fill_done = (r_state == ST_FILL_D);
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_fill_arbiter
// Description : Self-checking bench for mem_fill_arbiter with a transaction
//               scheduling model, a latency memory and random requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_fill_arbiter;

    localparam int LAT    = 4;
    localparam int MAXC   = 4096;
    localparam int K_IDLE = 0;
    localparam int K_WR   = 1;
    localparam int K_FILL = 2;

    typedef struct packed {
        logic        mem_en;
        logic        mem_wr;
        logic [15:0] mem_addr;
        logic [15:0] mem_data_in;
        logic [15:0] fill_data;
        logic [2:0]  fill_word;
        logic        i_fill_valid;
        logic        d_fill_valid;
        logic        i_fill_done;
        logic        d_fill_done;
        logic        d_wr_ack;
        logic        busy;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss_req;
    logic [15:0] i_miss_addr;
    logic        d_miss_req;
    logic [15:0] d_miss_addr;
    logic        d_wr_req;
    logic [15:0] d_wr_addr;
    logic [15:0] d_wr_data;
    logic        mem_data_valid;
    logic [15:0] mem_data_out;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_valid;
    logic        d_fill_valid;
    logic        i_fill_done;
    logic        d_fill_done;
    logic        d_wr_ack;
    logic        busy;

    mem_fill_arbiter #(
        .MEM_LATENCY     (LAT),
        .WORDS_PER_BLOCK (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_miss_req     (i_miss_req),
        .i_miss_addr    (i_miss_addr),
        .d_miss_req     (d_miss_req),
        .d_miss_addr    (d_miss_addr),
        .d_wr_req       (d_wr_req),
        .d_wr_addr      (d_wr_addr),
        .d_wr_data      (d_wr_data),
        .mem_data_valid (mem_data_valid),
        .mem_data_out   (mem_data_out),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .i_fill_valid   (i_fill_valid),
        .d_fill_valid   (d_fill_valid),
        .i_fill_done    (i_fill_done),
        .d_fill_done    (d_fill_done),
        .d_wr_ack       (d_wr_ack),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cyc = -1;
    always @(posedge clk) cyc <= cyc + 1;

    out_t act;
    assign act = {mem_en, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
                  i_fill_valid, d_fill_valid, i_fill_done, d_fill_done, d_wr_ack, busy};

    out_t        exp_q  [MAXC];
    int          kind_q [MAXC];
    logic        ret_v  [MAXC];
    logic [15:0] ret_d  [MAXC];
    logic [15:0] mem    [32768];

    int checks = 0;
    int errors = 0;
    int free_at = 0;
    bit i_inflight = 1'b0;
    bit d_inflight = 1'b0;
    bit rand_en = 1'b0;
    int t;

    always @(negedge clk) begin
        if (cyc >= 0 && cyc < MAXC) begin
            checks++;
            if (act !== exp_q[cyc]) begin
                errors++;
                $display("FAIL cycle_outputs cyc=%0d got=%h want=%h", cyc, act, exp_q[cyc]);
            end
        end
    end

    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'hFFF0 | 16'($urandom_range(0, 15));
        return 16'($urandom);
    endfunction

    task automatic stim_update();
        if (rand_en) begin
            if (!d_wr_req && $urandom_range(0, 5) == 0) begin
                d_wr_req  = 1'b1;
                d_wr_addr = rand_addr();
                d_wr_data = 16'($urandom);
            end
            if (!d_miss_req && !d_inflight && $urandom_range(0, 7) == 0) begin
                d_miss_req  = 1'b1;
                d_miss_addr = rand_addr();
            end
            if (!i_miss_req && !i_inflight && $urandom_range(0, 7) == 0) begin
                i_miss_req  = 1'b1;
                i_miss_addr = rand_addr();
            end
            if (i_miss_req && i_inflight && $urandom_range(0, 15) == 0) i_miss_req = 1'b0;
        end
    endtask

    // Memory capture plus transaction-level prediction for cycle n.
    task automatic model_update(input int n);
        logic [15:0] base;
        logic [15:0] a;
        bit          is_d;
        if (mem_en === 1'b1) begin
            if (mem_wr === 1'b1) begin
                if (!rst) mem[mem_addr[15:1]] = mem_data_in;
            end else if (n + LAT < MAXC) begin
                ret_v[n+LAT] = 1'b1;
                ret_d[n+LAT] = mem[mem_addr[15:1]];
            end
        end
        if (rst) begin
            for (int c = n + 1; c <= n + LAT + 12 && c < MAXC; c++) begin
                exp_q[c]  = '0;
                kind_q[c] = K_IDLE;
                ret_v[c]  = 1'b0;
            end
            free_at    = n + 1;
            i_miss_req = 1'b0;
            d_miss_req = 1'b0;
            d_wr_req   = 1'b0;
            i_inflight = 1'b0;
            d_inflight = 1'b0;
        end else if (n >= free_at) begin
            if (d_wr_req) begin
                exp_q[n+1].mem_en      = 1'b1;
                exp_q[n+1].mem_wr      = 1'b1;
                exp_q[n+1].mem_addr    = d_wr_addr;
                exp_q[n+1].mem_data_in = d_wr_data;
                exp_q[n+1].d_wr_ack    = 1'b1;
                exp_q[n+1].busy        = 1'b1;
                kind_q[n+1]            = K_WR;
                free_at                = n + 2;
            end else if (d_miss_req || i_miss_req) begin
                is_d = d_miss_req;
                base = (is_d ? d_miss_addr : i_miss_addr) & 16'hFFF0;
                for (int c = n + 1; c <= n + 8 + LAT; c++) begin
                    exp_q[c].busy = 1'b1;
                    kind_q[c]     = K_FILL;
                end
                for (int k = 0; k < 8; k++) begin
                    a = base + 16'(2 * k);
                    exp_q[n+1+k].mem_en       = 1'b1;
                    exp_q[n+1+k].mem_addr     = a;
                    exp_q[n+1+LAT+k].fill_data    = mem[a[15:1]];
                    exp_q[n+1+LAT+k].fill_word    = 3'(k);
                    exp_q[n+1+LAT+k].i_fill_valid = !is_d;
                    exp_q[n+1+LAT+k].d_fill_valid = is_d;
                end
                exp_q[n+8+LAT].i_fill_done = !is_d;
                exp_q[n+8+LAT].d_fill_done = is_d;
                free_at = n + 9 + LAT;
                if (is_d) d_inflight = 1'b1;
                else      i_inflight = 1'b1;
            end
        end
        if (exp_q[n].d_wr_ack)    d_wr_req = 1'b0;
        if (exp_q[n].d_fill_done) begin d_miss_req = 1'b0; d_inflight = 1'b0; end
        if (exp_q[n].i_fill_done) begin i_miss_req = 1'b0; i_inflight = 1'b0; end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step();
        stim_update();
        model_update(cyc);
        @(posedge clk);
        #1;
        if (ret_v[cyc]) begin
            mem_data_valid = 1'b1;
            mem_data_out   = ret_d[cyc];
        end else begin
            mem_data_valid = (kind_q[cyc] != K_FILL) && ($urandom_range(0, 2) == 0);
            mem_data_out   = 16'($urandom);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int c = 0; c < MAXC; c++) begin
            exp_q[c]  = '0;
            kind_q[c] = K_IDLE;
            ret_v[c]  = 1'b0;
            ret_d[c]  = '0;
        end
        for (int w = 0; w < 32768; w++) mem[w] = 16'($urandom);
        rst = 1'b1;
        i_miss_req = 1'b0; i_miss_addr = '0;
        d_miss_req = 1'b0; d_miss_addr = '0;
        d_wr_req = 1'b0; d_wr_addr = '0; d_wr_data = '0;
        mem_data_valid = 1'b0; mem_data_out = '0;
        @(negedge clk);
        #1;
        repeat (3) step();
        rst = 1'b0;
        lit("reset_busy", busy, 0);
        lit("reset_outputs", act, 0);

        // I fill of block 0x0120
        t = cyc;
        i_miss_req = 1'b1; i_miss_addr = 16'h0126;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) lit("s1_first_read", {mem_en, mem_wr, mem_addr}, {2'b10, 16'h0120});
            if (k == 5) lit("s1_first_return", {i_fill_valid, fill_word, fill_data}, {1'b1, 3'd0, mem[15'h0090]});
            if (k == 8) lit("s1_last_read", mem_addr, 16'h012E);
            if (k == 12) lit("s1_done", {i_fill_done, fill_word}, {1'b1, 3'd7});
            if (k == 12) lit("s1_model_done", exp_q[t+12].i_fill_done, 1);
            if (k == 13) lit("s1_idle", busy, 0);
        end

        // Simultaneous I and D misses: D first
        t = cyc;
        i_miss_req = 1'b1; i_miss_addr = 16'h1230;
        d_miss_req = 1'b1; d_miss_addr = 16'h4008;
        for (int k = 1; k <= 26; k++) begin
            step();
            if (k == 1) lit("s2_d_first_read", mem_addr, 16'h4000);
            if (k == 5) lit("s2_d_return", {i_fill_valid, d_fill_valid}, 2'b01);
            if (k == 12) lit("s2_d_done", d_fill_done, 1);
            if (k == 13) lit("s2_gap_idle", busy, 0);
            if (k == 14) lit("s2_i_first_read", {mem_en, mem_addr}, {1'b1, 16'h1230});
            if (k == 25) lit("s2_i_done", i_fill_done, 1);
        end

        // Store beats a pending D miss
        t = cyc;
        d_wr_req = 1'b1; d_wr_addr = 16'h2002; d_wr_data = 16'hBEEF;
        d_miss_req = 1'b1; d_miss_addr = 16'h2010;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 1) lit("s3_write", {mem_en, mem_wr, mem_addr, mem_data_in, d_wr_ack},
                            {2'b11, 16'h2002, 16'hBEEF, 1'b1});
            if (k == 2) lit("s3_idle_gap", busy, 0);
            if (k == 3) lit("s3_fill_start", {mem_en, mem_addr}, {1'b1, 16'h2010});
            if (k == 14) lit("s3_fill_done", d_fill_done, 1);
        end

        // Top-of-memory block does not carry
        t = cyc;
        d_miss_req = 1'b1; d_miss_addr = 16'hFFF4;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 1) lit("s4_first_read", mem_addr, 16'hFFF0);
            if (k == 8) lit("s4_last_read", mem_addr, 16'hFFFE);
            if (k == 12) lit("s4_done", d_fill_done, 1);
        end

        // Reset in the middle of an I fill, then a clean fill
        t = cyc;
        i_miss_req = 1'b1; i_miss_addr = 16'h0300;
        for (int k = 1; k <= 14; k++) begin
            step();
            rst = (k == 6);
            if (k == 7) lit("s5_after_reset", act, 0);
            if (k == 12) lit("s5_no_done", i_fill_done, 0);
        end
        t = cyc;
        i_miss_req = 1'b1; i_miss_addr = 16'h0500;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 1) lit("s5_refill_read", mem_addr, 16'h0500);
            if (k == 12) lit("s5_refill_done", i_fill_done, 1);
        end

        // Requester drops its miss mid-fill
        t = cyc;
        i_miss_req = 1'b1; i_miss_addr = 16'h0A18;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 3) i_miss_req = 1'b0;
            if (k == 12) lit("s6_done", {i_fill_done, fill_word}, {1'b1, 3'd7});
        end

        // Random traffic with occasional resets
        rand_en = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        rand_en = 1'b0;
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
